spi_master_if: RTL and testbench
================================

Name: spi_master_if

Overview:
- SPI master for the register-file command protocol: drives chip select, serial clock and MOSI; captures MISO.
- One transaction is an 8-bit command byte followed by a DATA_WIDTH data word:
  - Command byte: bit7 = R/W (1 = read, 0 = write); bits6:0 = register address.
- Used on the bench and board-level test logic to read and write registers of the SPI register-file slave.
- Timing is generated from sys_clk_i so the slave's 2-flop synchronisers resolve every SCLK level.

Parameters:
- CLK_DIV, 4: SCLK half-period in sys_clk_i cycles; legal range 2..255.
- ADDR_WIDTH, 7: register address width; the command byte is 1 + ADDR_WIDTH = 8 bits.
- DATA_WIDTH, 16: data word width.

Ports:
- sys_clk_i  in  1  system clock
- sys_rst_i  in  1  reset, synchronous, active-high
- start_i  in  1  transaction request; sampled only while busy_o = 0
- rw_i  in  1  1 = read, 0 = write
- addr_i  in  ADDR_WIDTH  register address
- wdata_i  in  DATA_WIDTH  write data; sent for reads too
- rdata_o  out  DATA_WIDTH  last read data
- busy_o  out  1  transaction in progress
- done_o  out  1  one-cycle completion pulse
- spi_cs_o  out  1  chip select, active low
- spi_clk_o  out  1  SCLK, idle low (mode 0)
- spi_mosi_o  out  1  master data out, MSB first
- spi_miso_i  in  1  slave data in

Behaviour:
- Reset (synchronous) values:
  - spi_cs_o = 1, spi_clk_o = 0, spi_mosi_o = 0.
  - busy_o = 0, done_o = 0, rdata_o = 0.
  - FSM goes to IDLE.
  - Reset mid-transaction aborts immediately; CS rises on the next edge and no done_o is issued.
- FSM states:
  - IDLE: wait for start_i.
  - SETUP: CS low, first bit on MOSI.
  - SHIFT: clocking out bits.
  - HOLD: CS still low after the last SCLK falling edge.
  - GAP: CS high, busy still asserted.
- Shift register width is N = 8 + DATA_WIDTH = 24 by default.
- Cycle T0: start_i = 1 in IDLE.
  - Latch the tx word {rw_i, addr_i, wdata_i}.
  - busy_o = 1 from T1.
- T1: spi_cs_o = 0, spi_mosi_o = tx[N-1]; enter SETUP.
- Edge timing, k = 0..N-1:
  - SCLK rising edge at T1 + CLK_DIV*(2k+1).
  - SCLK falling edge at T1 + CLK_DIV*(2k+2).
- MISO sampling:
  - Sampled in the sys cycle immediately before each falling edge, i.e. at the end of the high phase.
  - Shifted into rx, MSB first.
- MOSI update:
  - Changes only together with a falling edge, to the next bit.
  - After the last bit, MOSI = 0.
- Last falling edge at T1 + 2N*CLK_DIV; then HOLD for CLK_DIV cycles.
- CS release:
  - spi_cs_o = 1 at T1 + (2N+1)*CLK_DIV.
  - Then GAP for CLK_DIV cycles.
- Completion at T1 + (2N+2)*CLK_DIV:
  - done_o = 1 for one cycle and busy_o = 0.
  - rdata_o = rx[DATA_WIDTH-1:0], for reads only; writes leave rdata_o unchanged.
  - The 8 rx bits captured during the command byte are discarded.
- Back-to-back operation:
  - start_i is accepted in the done_o cycle.
  - Minimum CS-high time is CLK_DIV + 1 cycles.
- start_i while busy_o = 1 is ignored; no queueing.
- Input fields are latched at T0; later changes have no effect.
- Half-period counter:
  - Reloads to CLK_DIV-1 on each phase and counts down to 0.
  - The state/SCLK transition occurs on the cycle after the count reaches 0.
- Bit counter counts 0..N-1 and saturates; it never wraps within a transaction.

Decomposition:
- Shared defines header holds:
  - INT_CMD_WIDTH = 8
  - INT_CMD_CMD_MSK = 8'h80
  - INT_CMD_ADDR_MSK = 8'h7F
  - INT_CMD_READ = 8'h80
  - INT_CMD_WRITE = 8'h00
  - RST_ACT = 1
  - FSM state encodings
- Sub-module spi_clk_gen:
  - Half-period counter with load/enable.
  - Emits one-cycle tick_o at the end of each half-period.
  - The FSM uses tick_o to toggle SCLK, sample and shift.

Test Plan:
- Write: reset, then start_i with rw=0, addr=7'h05, wdata=16'hA5C3, CLK_DIV=4.
  - MOSI sequence = 24'h05A5C3 MSB first.
  - CS low for exactly 196 cycles.
  - 24 rising edges.
  - done_o at T1 + 200.
  - rdata_o stays 0.
- Read: rw=1, addr=7'h12; slave model drives 16'h3C5A on the data phase.
  - Command bits on MOSI = 8'h92.
  - rdata_o = 16'h3C5A in the done_o cycle.
- Back-to-back: start_i held high continuously.
  - Second CS falling edge occurs exactly CLK_DIV + 1 cycles after the first CS rising edge.
  - Exactly two done_o pulses over the window.
- Ignore-while-busy: pulse start_i with addr=7'h7F mid-transaction.
  - The in-flight frame is unchanged.
  - No extra transaction occurs.
- Reset mid-SHIFT: assert sys_rst_i after 10 bits.
  - Next cycle: CS = 1, SCLK = 0, busy_o = 0, no done_o, rdata_o = 0.
  - A new transaction after reset completes normally.
- CLK_DIV = 2 with a loopback slave (MISO = delayed MOSI):
  - rdata_o equals the data field sent.
  - SCLK high/low phases are exactly 2 cycles each.

Source files
------------

// File: rtl/spi_master_if_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | spi_master_if_pkg                                                    |
// | Shared command-byte fields, reset level and FSM encodings.           |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package spi_master_if_pkg;

    localparam int unsigned INT_CMD_WIDTH    = 8;
    localparam logic [7:0]  INT_CMD_CMD_MSK  = 8'h80;
    localparam logic [7:0]  INT_CMD_ADDR_MSK = 8'h7F;
    localparam logic [7:0]  INT_CMD_READ     = 8'h80;
    localparam logic [7:0]  INT_CMD_WRITE    = 8'h00;

    localparam logic        RST_ACT = 1'b1;

    localparam logic [2:0]  ST_IDLE  = 3'd0;
    localparam logic [2:0]  ST_SETUP = 3'd1;
    localparam logic [2:0]  ST_SHIFT = 3'd2;
    localparam logic [2:0]  ST_HOLD  = 3'd3;
    localparam logic [2:0]  ST_GAP   = 3'd4;

    typedef enum logic [2:0] {
        IDLE  = ST_IDLE,
        SETUP = ST_SETUP,
        SHIFT = ST_SHIFT,
        HOLD  = ST_HOLD,
        GAP   = ST_GAP
    } state_e;

endpackage
`default_nettype wire

// File: rtl/spi_master_if_clk_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | spi_clk_gen                                                          |
// | Half-period down-counter; tick_o marks the last cycle of a phase.    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module spi_clk_gen
    import spi_master_if_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic load_i,
    input  logic en_i,
    output logic tick_o
);

    localparam logic [7:0] c_RELOAD = 8'(CLK_DIV - 1);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i || (en_i && (cnt_q == 8'd0))) begin
            cnt_d = c_RELOAD;
        end else if (en_i) begin
            cnt_d = cnt_q - 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst == RST_ACT) begin
            cnt_q <= c_RELOAD;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = en_i && !load_i && (cnt_q == 8'd0);

endmodule
`default_nettype wire

// File: rtl/spi_master_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | spi_master_if                                                        |
// | Mode-0 SPI master: command byte + data word, MSB first.              |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module spi_master_if
    import spi_master_if_pkg::*;
#(
    parameter int unsigned CLK_DIV    = 4,
    parameter int unsigned ADDR_WIDTH = 7,
    parameter int unsigned DATA_WIDTH = 16
) (
    input  logic                  sys_clk_i,
    input  logic                  sys_rst_i,
    input  logic                  start_i,
    input  logic                  rw_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  spi_cs_o,
    output logic                  spi_clk_o,
    output logic                  spi_mosi_o,
    input  logic                  spi_miso_i
);

    localparam int unsigned    c_N    = INT_CMD_WIDTH + DATA_WIDTH;
    localparam int unsigned    c_BW   = $clog2(c_N);
    localparam logic [c_BW-1:0] c_LAST = c_BW'(c_N - 1);

    state_e                  state_q, state_d;
    logic [c_N-2:0]          tx_q, tx_d;
    logic [DATA_WIDTH-1:0]   rx_q, rx_d;
    logic [c_BW-1:0]         bit_q, bit_d;
    logic                    rd_q, rd_d;
    logic                    cs_q, cs_d;
    logic                    sclk_q, sclk_d;
    logic                    mosi_q, mosi_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;

    logic                    w_start;
    logic                    w_tick;
    logic [INT_CMD_WIDTH-1:0] w_addr_ext;
    logic [INT_CMD_WIDTH-1:0] w_cmd;

    assign w_start = start_i && (state_q == IDLE);

    always_comb begin
        w_addr_ext = '0;
        w_addr_ext[ADDR_WIDTH-1:0] = addr_i;
        w_cmd = (rw_i ? INT_CMD_READ : INT_CMD_WRITE) | (w_addr_ext & INT_CMD_ADDR_MSK);
    end

    spi_clk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_gen (
        .clk    (sys_clk_i),
        .rst    (sys_rst_i),
        .load_i (w_start),
        .en_i   (state_q != IDLE),
        .tick_o (w_tick)
    );

    always_comb begin
        state_d = state_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        bit_d   = bit_q;
        rd_d    = rd_q;
        cs_d    = cs_q;
        sclk_d  = sclk_q;
        mosi_d  = mosi_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                if (w_start) begin
                    // MSB goes straight to MOSI; tx holds the remaining N-1 bits
                    tx_d    = {w_cmd[INT_CMD_WIDTH-2:0], wdata_i};
                    rd_d    = |(w_cmd & INT_CMD_CMD_MSK);
                    mosi_d  = w_cmd[INT_CMD_WIDTH-1];
                    rx_d    = '0;
                    bit_d   = '0;
                    cs_d    = 1'b0;
                    busy_d  = 1'b1;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (w_tick) begin
                    sclk_d  = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (w_tick) begin
                    if (sclk_q) begin
                        sclk_d = 1'b0;
                        rx_d   = {rx_q[DATA_WIDTH-2:0], spi_miso_i};
                        if (bit_q == c_LAST) begin
                            mosi_d  = 1'b0;
                            state_d = HOLD;
                        end else begin
                            bit_d  = bit_q + c_BW'(1);
                            mosi_d = tx_q[c_N-2];
                            tx_d   = {tx_q[c_N-3:0], 1'b0};
                        end
                    end else begin
                        sclk_d = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (w_tick) begin
                    cs_d    = 1'b1;
                    state_d = GAP;
                end
            end
            GAP: begin
                if (w_tick) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                    if (rd_q) begin
                        rdata_d = rx_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i == RST_ACT) begin
            state_q <= IDLE;
            tx_q    <= '0;
            rx_q    <= '0;
            bit_q   <= '0;
            rd_q    <= 1'b0;
            cs_q    <= 1'b1;
            sclk_q  <= 1'b0;
            mosi_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            bit_q   <= bit_d;
            rd_q    <= rd_d;
            cs_q    <= cs_d;
            sclk_q  <= sclk_d;
            mosi_q  <= mosi_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            rdata_q <= rdata_d;
        end
    end

    assign rdata_o    = rdata_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign spi_cs_o   = cs_q;
    assign spi_clk_o  = sclk_q;
    assign spi_mosi_o = mosi_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_master_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_spi_master_if                                                     |
// | Directed bench: CLK_DIV=4 instance plus a CLK_DIV=2 loopback one.    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_spi_master_if;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        start = 1'b0, rw = 1'b0, miso = 1'b0;
    logic [6:0]  addr = '0;
    logic [15:0] wdata = '0;
    logic [15:0] rdata;
    logic        busy, done, cs, sclk, mosi;

    logic        start2 = 1'b0, rw2 = 1'b0, miso2 = 1'b0;
    logic [6:0]  addr2 = '0;
    logic [15:0] wdata2 = '0;
    logic [15:0] rdata2;
    logic        busy2, done2, cs2, sclk2, mosi2;

    spi_master_if #(.CLK_DIV(4), .ADDR_WIDTH(7), .DATA_WIDTH(16)) dut (
        .sys_clk_i(clk), .sys_rst_i(rst), .start_i(start), .rw_i(rw),
        .addr_i(addr), .wdata_i(wdata), .rdata_o(rdata), .busy_o(busy),
        .done_o(done), .spi_cs_o(cs), .spi_clk_o(sclk), .spi_mosi_o(mosi),
        .spi_miso_i(miso)
    );

    spi_master_if #(.CLK_DIV(2), .ADDR_WIDTH(7), .DATA_WIDTH(16)) dut2 (
        .sys_clk_i(clk), .sys_rst_i(rst), .start_i(start2), .rw_i(rw2),
        .addr_i(addr2), .wdata_i(wdata2), .rdata_o(rdata2), .busy_o(busy2),
        .done_o(done2), .spi_cs_o(cs2), .spi_clk_o(sclk2), .spi_mosi_o(mosi2),
        .spi_miso_i(miso2)
    );

    // loopback slave: MISO is MOSI delayed by one system cycle
    always @(posedge clk) miso2 <= mosi2;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // t = 0 is the first cycle after the accepting edge (T1)
    task automatic run_frame(input logic i_rw, input logic [6:0] i_addr,
                             input logic [15:0] i_wdata, input logic [23:0] miso_word,
                             input int pulse_at,
                             output logic [23:0] mosi_word, output int rises,
                             output int cs_low, output int done_t, output logic [15:0] rd);
        int   falls;
        logic prev_sclk;
        mosi_word = '0; rises = 0; cs_low = 0; done_t = -1; falls = 0; rd = '0;
        prev_sclk = 1'b0;
        @(negedge clk);
        start = 1'b1; rw = i_rw; addr = i_addr; wdata = i_wdata; miso = miso_word[23];
        @(posedge clk);
        for (int t = 0; t < 600; t++) begin
            @(negedge clk);
            if (t == 0) begin
                start = 1'b0; rw = ~i_rw; addr = ~i_addr; wdata = ~i_wdata;
            end
            if (t == pulse_at) begin
                start = 1'b1; rw = 1'b1; addr = 7'h7F;
            end
            if (t == pulse_at + 1) start = 1'b0;
            if (!cs) cs_low++;
            if (sclk && !prev_sclk) begin
                rises++;
                mosi_word = {mosi_word[22:0], mosi};
            end
            if (!sclk && prev_sclk) begin
                falls++;
                if (falls < 24) miso = miso_word[23 - falls];
            end
            prev_sclk = sclk;
            if (done) begin
                done_t = t;
                rd = rdata;
                break;
            end
        end
        start = 1'b0;
    endtask

    task automatic idle_watch(input int n, output int active);
        active = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (!cs || busy || done) active++;
        end
    endtask

    logic [23:0] mw;
    logic [15:0] rd;
    int rises, cs_low, done_t, active;
    int ndone, rise_t, fall2_t, seen;
    logic prev_cs;
    int run, first_hi, first_lo, d2_t;
    logic prev_s;

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_cs", cs, 1);
        check("rst_sclk", sclk, 0);
        check("rst_mosi", mosi, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_rdata", rdata, 0);

        // write frame
        run_frame(1'b0, 7'h05, 16'hA5C3, 24'h0, -1, mw, rises, cs_low, done_t, rd);
        check("wr_mosi", mw, 24'h05A5C3);
        check("wr_cs_low", cs_low, 196);
        check("wr_rises", rises, 24);
        check("wr_done_t", done_t, 200);
        check("wr_rdata", rd, 16'h0000);
        @(negedge clk);
        check("wr_done_1cyc", done, 0);
        check("wr_busy_off", busy, 0);

        // read frame
        run_frame(1'b1, 7'h12, 16'h1234, 24'h003C5A, -1, mw, rises, cs_low, done_t, rd);
        check("rd_cmd", mw[23:16], 8'h92);
        check("rd_wdata_sent", mw[15:0], 16'h1234);
        check("rd_rdata", rd, 16'h3C5A);
        check("rd_done_t", done_t, 200);

        // start pulse mid-frame must be ignored; write must not touch rdata
        run_frame(1'b0, 7'h21, 16'h0F0F, 24'hFFFFFF, 50, mw, rises, cs_low, done_t, rd);
        check("ign_mosi", mw, 24'h210F0F);
        check("ign_done_t", done_t, 200);
        check("ign_rdata_kept", rd, 16'h3C5A);
        idle_watch(30, active);
        check("ign_no_extra", active, 0);

        // back-to-back with start held high
        @(negedge clk);
        start = 1'b1; rw = 1'b0; addr = 7'h01; wdata = 16'h0001;
        @(posedge clk);
        ndone = 0; rise_t = -1; fall2_t = -1; prev_cs = 1'b0;
        for (int t = 0; t < 410; t++) begin
            @(negedge clk);
            if (done) ndone++;
            if (cs && !prev_cs && rise_t < 0) rise_t = t;
            if (!cs && prev_cs && rise_t >= 0 && fall2_t < 0) fall2_t = t;
            prev_cs = cs;
        end
        start = 1'b0;
        check("b2b_rise_t", rise_t, 196);
        check("b2b_gap", fall2_t - rise_t, 5);
        check("b2b_ndone", ndone, 2);
        seen = 0;
        for (int t = 0; t < 400; t++) begin
            @(negedge clk);
            if (done) begin
                seen = 1;
                break;
            end
        end
        check("b2b_drain", seen, 1);

        // reset after 10 bits of a read
        @(negedge clk);
        start = 1'b1; rw = 1'b1; addr = 7'h12; wdata = 16'h1111; miso = 1'b1;
        @(posedge clk);
        ndone = 0; seen = 0; prev_s = 1'b0;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            start = 1'b0;
            if (!sclk && prev_s) ndone++;
            prev_s = sclk;
            if (ndone == 10) begin
                seen = 1;
                break;
            end
        end
        check("rstm_reached", seen, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rstm_cs", cs, 1);
        check("rstm_sclk", sclk, 0);
        check("rstm_busy", busy, 0);
        check("rstm_done", done, 0);
        check("rstm_rdata", rdata, 0);
        check("rstm_mosi", mosi, 0);
        idle_watch(20, active);
        check("rstm_quiet", active, 0);
        run_frame(1'b0, 7'h44, 16'h5AA5, 24'h0, -1, mw, rises, cs_low, done_t, rd);
        check("rstm_wr_mosi", mw, 24'h445AA5);
        check("rstm_wr_done_t", done_t, 200);

        // CLK_DIV = 2 loopback
        @(negedge clk);
        start2 = 1'b1; rw2 = 1'b1; addr2 = 7'h33; wdata2 = 16'hBEEF;
        @(posedge clk);
        run = 0; first_hi = -1; first_lo = -1; d2_t = -1; prev_s = 1'b0;
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            start2 = 1'b0;
            if (sclk2 == prev_s) begin
                run++;
            end else begin
                if (prev_s && first_hi < 0) first_hi = run;
                else if (!prev_s && first_hi >= 0 && first_lo < 0) first_lo = run;
                run = 1;
            end
            prev_s = sclk2;
            if (done2) begin
                d2_t = t;
                check("div2_rdata", rdata2, 16'hBEEF);
                break;
            end
        end
        check("div2_hi", first_hi, 2);
        check("div2_lo", first_lo, 2);
        check("div2_done_t", d2_t, 100);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
